// File: rtl/iq_sample_repeater_if.sv
// -----------------------------------------------------------------------------
// iq_sample_repeater_if
// Bundles the configuration, input-stream and output-stream handshakes of the
// I/Q sample repeater into a single interface.
//
// Signals:
//   cfg_factor      requested output beats per input sample (CNT_W bits)
//   cfg_zero_stuff  0 = hold mode, 1 = zero-stuff mode
//   in_valid/in_ready, in_i/in_q        input sample stream (two's complement)
//   out_valid/out_ready, out_i/out_q,
//   out_last                            output beat stream
//
// Modports:
//   slave  : the repeater's view (consumes the input stream, drives output)
//   master : the environment's view (drives input stream and out_ready)
// -----------------------------------------------------------------------------
interface iq_sample_repeater_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 4
);
    logic [CNT_W-1:0]  cfg_factor;
    logic              cfg_zero_stuff;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_i;
    logic [DATA_W-1:0] in_q;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_i;
    logic [DATA_W-1:0] out_q;
    logic              out_last;

    modport slave (
        input  cfg_factor, cfg_zero_stuff,
        input  in_valid, in_i, in_q,
        output in_ready,
        output out_valid, out_i, out_q, out_last,
        input  out_ready
    );

    modport master (
        output cfg_factor, cfg_zero_stuff,
        output in_valid, in_i, in_q,
        input  in_ready,
        input  out_valid, out_i, out_q, out_last,
        output out_ready
    );
endinterface

// File: rtl/iq_sample_repeater.sv
// -----------------------------------------------------------------------------
// iq_sample_repeater
// Zero-order-hold / zero-stuff interpolator for the TX I/Q path. Each accepted
// input sample is emitted as F output beats, each under its own valid/ready
// handshake. F and the mode are latched when the sample is accepted. A new
// sample can be accepted in the same cycle as the final beat's handshake so
// back-to-back samples stream without a bubble.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   bus           iq_sample_repeater_if.slave (config, input and output streams)
//   underrun_cnt  16-bit saturating count of cycles with out_ready=1 and
//                 out_valid=0 (only with IQ_REPEATER_UNDERRUN_CNT_EN defined)
//
// Optional build macro: IQ_REPEATER_UNDERRUN_CNT_EN
// -----------------------------------------------------------------------------
module iq_sample_repeater #(
    parameter int DATA_W     = 12,
    parameter int MAX_FACTOR = 8,
    parameter int CNT_W      = $clog2(MAX_FACTOR + 1)
) (
    input  logic clk,
    input  logic rst,
`ifdef IQ_REPEATER_UNDERRUN_CNT_EN
    output logic [15:0] underrun_cnt,
`endif
    iq_sample_repeater_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;        // beats still to be emitted after the current one
    logic              zero_mode_q;  // latched mode of the sample in flight
    logic [DATA_W-1:0] hold_i_q;
    logic [DATA_W-1:0] hold_q_q;
    logic [DATA_W-1:0] out_i_q;
    logic [DATA_W-1:0] out_q_q;
    logic              out_valid_q;
    logic              out_last_q;

    logic [CNT_W-1:0]  factor_d;     // effective factor derived from cfg_factor
    logic              in_ready_d;
    logic              accept_d;
    logic              out_hs_d;

    // Effective factor: 0 means 1, anything above MAX_FACTOR is clamped.
    always_comb begin
        factor_d = bus.cfg_factor;
        if (bus.cfg_factor == '0) begin
            factor_d = CNT_W'(1);
        end else if (bus.cfg_factor > CNT_W'(MAX_FACTOR)) begin
            factor_d = CNT_W'(MAX_FACTOR);
        end
    end

    assign out_hs_d   = out_valid_q && bus.out_ready;
    // Ready when idle, or when the last beat of the current sample is leaving.
    assign in_ready_d = !rst && ((state_q == IDLE) || (out_hs_d && out_last_q));
    assign accept_d   = bus.in_valid && in_ready_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            zero_mode_q <= 1'b0;
            hold_i_q    <= '0;
            hold_q_q    <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (accept_d) begin
            // New sample (possibly replacing a final beat in the same cycle).
            state_q     <= ACTIVE;
            hold_i_q    <= bus.in_i;
            hold_q_q    <= bus.in_q;
            zero_mode_q <= bus.cfg_zero_stuff;
            out_i_q     <= bus.in_i;
            out_q_q     <= bus.in_q;
            out_valid_q <= 1'b1;
            out_last_q  <= (factor_d == CNT_W'(1));
            cnt_q       <= factor_d - CNT_W'(1);
        end else if (state_q == ACTIVE && out_hs_d) begin
            if (out_last_q) begin
                // Data registers keep their last value while idle.
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                cnt_q      <= cnt_q - CNT_W'(1);
                out_i_q    <= zero_mode_q ? '0 : hold_i_q;
                out_q_q    <= zero_mode_q ? '0 : hold_q_q;
                out_last_q <= (cnt_q == CNT_W'(1));
            end
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_i     = out_i_q;
    assign bus.out_q     = out_q_q;
    assign bus.out_last  = out_last_q;

`ifdef IQ_REPEATER_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= '0;
        end else if (bus.out_ready && !out_valid_q && underrun_q != 16'hFFFF) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_iq_sample_repeater.sv
// -----------------------------------------------------------------------------
// tb_iq_sample_repeater
// Randomized bench for iq_sample_repeater. A queue of expected output beats is
// built from each accepted sample (F copies, or sample followed by zeros) and
// compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_iq_sample_repeater;

    localparam int DATA_W     = 12;
    localparam int MAX_FACTOR = 8;
    localparam int CNT_W      = $clog2(MAX_FACTOR + 1);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    iq_sample_repeater_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

`ifdef IQ_REPEATER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    iq_sample_repeater #(
        .DATA_W    (DATA_W),
        .MAX_FACTOR(MAX_FACTOR),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef IQ_REPEATER_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .bus         (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] i;
        logic [DATA_W-1:0] q;
        logic              last;
    } beat_t;

    beat_t             exp_beats[$];
    logic [DATA_W-1:0] last_i;
    logic [DATA_W-1:0] last_q;
    int unsigned       exp_under;
    int                errors = 0;
    int                checks = 0;
    int                n_accept = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model to what the next edge should produce.
    task automatic cycle(input logic r, input logic iv,
                         input logic [DATA_W-1:0] di, input logic [DATA_W-1:0] dq,
                         input logic [CNT_W-1:0] cf, input logic cz, input logic ordy);
        logic  busy;
        logic  exp_ready;
        int    f;
        beat_t b;
        @(negedge clk);
        rst                = r;
        bus.in_valid       = iv;
        bus.in_i           = di;
        bus.in_q           = dq;
        bus.cfg_factor     = cf;
        bus.cfg_zero_stuff = cz;
        bus.out_ready      = ordy;
        #1;
        busy      = (exp_beats.size() > 0);
        exp_ready = !r && (!busy || (exp_beats.size() == 1 && ordy));
        check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, busy});
        if (busy) begin
            check_val("out_i", {20'd0, bus.out_i}, {20'd0, exp_beats[0].i});
            check_val("out_q", {20'd0, bus.out_q}, {20'd0, exp_beats[0].q});
            check_val("out_last", {31'd0, bus.out_last}, {31'd0, exp_beats[0].last});
        end else begin
            check_val("idle_i", {20'd0, bus.out_i}, {20'd0, last_i});
            check_val("idle_q", {20'd0, bus.out_q}, {20'd0, last_q});
            check_val("idle_last", {31'd0, bus.out_last}, 32'd0);
        end
`ifdef IQ_REPEATER_UNDERRUN_CNT_EN
        check_val("underrun", {16'd0, underrun_cnt}, exp_under);
`endif
        if (r) begin
            exp_beats.delete();
            last_i    = '0;
            last_q    = '0;
            exp_under = 0;
        end else begin
            if (!busy && ordy && exp_under < 32'hFFFF) exp_under++;
            if (busy && ordy) begin
                b      = exp_beats.pop_front();
                last_i = b.i;
                last_q = b.q;
            end
            if (iv && exp_ready) begin
                n_accept++;
                f = (cf == 0) ? 1 : ((int'(cf) > MAX_FACTOR) ? MAX_FACTOR : int'(cf));
                for (int k = 0; k < f; k++) begin
                    b.i    = (k == 0 || !cz) ? di : '0;
                    b.q    = (k == 0 || !cz) ? dq : '0;
                    b.last = (k == f - 1);
                    exp_beats.push_back(b);
                end
            end
        end
    endtask

    // Per-phase probabilities (percent): in_valid, out_ready, reset.
    int iv_pct[5]  = '{50, 100, 70, 60, 100};
    int or_pct[5]  = '{100, 100, 50, 80, 30};
    int rst_pct[5] = '{0, 0, 0, 2, 1};

    initial begin
        rst                = 1'b1;
        bus.in_valid       = 1'b0;
        bus.in_i           = '0;
        bus.in_q           = '0;
        bus.cfg_factor     = '0;
        bus.cfg_zero_stuff = 1'b0;
        bus.out_ready      = 1'b0;
        exp_under          = 0;
        last_i             = '0;
        last_q             = '0;
        repeat (2) @(posedge clk);

        for (int p = 0; p < 5; p++) begin
            for (int n = 0; n < 600; n++) begin
                cycle(($urandom_range(99) < rst_pct[p]),
                      ($urandom_range(99) < iv_pct[p]),
                      DATA_W'($urandom), DATA_W'($urandom),
                      CNT_W'($urandom_range(15)),
                      1'($urandom),
                      ($urandom_range(99) < or_pct[p]));
            end
        end

        // Drain, then sit idle with out_ready high.
        for (int n = 0; n < 20; n++) begin
            cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        end
`ifdef IQ_REPEATER_UNDERRUN_CNT_EN
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 70010; n++) begin
            cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        end
`endif

        check_val("accepts_seen", {31'd0, (n_accept > 100)}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
